// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: opcodes, instruction field positions,
// ALUOp encodings and the registered EX control bundle.
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 16;
  localparam int FUNCT_W   = 6;
  localparam int OP_W      = 6;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   regdst;
    logic   alusrc;
    logic   memtoreg;
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   branch;
    aluop_e aluop;
  } ex_ctrl_t;

  function automatic logic [OP_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags when the load in EX writes a register
// that the instruction in ID reads as an operand.
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              id_jump,
  input  logic              id_memwrite,
  input  logic              id_branch,
  output logic              lu
);

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              uses_rs;
  logic              uses_rt;
  logic              rs_match;
  logic              rt_match;
  logic              unused_instr_bits;

  assign id_rs = id_instr[RS_LSB +: REG_AW];
  assign id_rt = id_instr[RT_LSB +: REG_AW];
  assign unused_instr_bits = ^id_instr[RT_LSB-1:0];

  // Loads (rt is a destination) and jumps do not read rt; stores, branches
  // and R-type instructions do.
  assign uses_rs = id_valid & ~id_jump;
  assign uses_rt = id_valid & ((opcode_of(id_instr) == OP_RTYPE) | id_memwrite | id_branch);

  assign rs_match = uses_rs & (ex_rt == id_rs);
  assign rt_match = uses_rt & (ex_rt == id_rt);

  assign lu = ex_valid & ex_memread & (ex_rt != '0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and downstream hold.
// Optional bubble counter on hz_count is built when HAZARD_CNT_EN is defined.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [1:0]        id_aluop,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic [1:0]        ex_aluop,
  output logic [15:0]       hz_count
);

  logic              ex_valid_q,   ex_valid_d;
  ex_ctrl_t          ex_ctrl_q,    ex_ctrl_d;
  logic [DATA_W-1:0] ex_pc4_q,     ex_pc4_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_rd_q,      ex_rd_d;
  logic [5:0]        ex_funct_q,   ex_funct_d;

  logic              lu;
  logic              insert_bubble;
  logic [DATA_W-1:0] imm_ext;
  ex_ctrl_t          id_ctrl;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .ex_valid   (ex_valid_q),
    .ex_memread (ex_ctrl_q.memread),
    .ex_rt      (ex_rt_q),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_jump    (id_jump),
    .id_memwrite(id_memwrite),
    .id_branch  (id_branch),
    .lu         (lu)
  );

  // Hold dominates: a frozen EX keeps its load, so the bubble waits for release.
  assign insert_bubble = lu & ~ex_hold;
  assign stall         = (lu | ex_hold) & ~reset;

  assign imm_ext[IMM_W-1:0] = id_instr[IMM_LSB +: IMM_W];
  genvar gi;
  generate
    for (gi = IMM_W; gi < DATA_W; gi++) begin : g_sext
      assign imm_ext[gi] = id_instr[IMM_LSB + IMM_W - 1];
    end
  endgenerate

  always_comb begin
    id_ctrl          = '0;
    id_ctrl.regdst   = id_regdst;
    id_ctrl.alusrc   = id_alusrc;
    id_ctrl.memtoreg = id_memtoreg;
    id_ctrl.regwrite = id_regwrite;
    id_ctrl.memread  = id_memread;
    id_ctrl.memwrite = id_memwrite;
    id_ctrl.branch   = id_branch;
    id_ctrl.aluop    = aluop_e'(id_aluop);
  end

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_pc4_d     = ex_pc4_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_funct_d   = ex_funct_q;
    if (!ex_hold) begin
      if (insert_bubble) begin
        // Bubble kills only valid/control; data and specifiers are don't-care.
        ex_valid_d = 1'b0;
        ex_ctrl_d  = '0;
      end else begin
        ex_valid_d   = id_valid;
        ex_ctrl_d    = id_valid ? id_ctrl : '0;
        ex_pc4_d     = id_pc4;
        ex_rs_data_d = id_rs_data;
        ex_rt_data_d = id_rt_data;
        ex_imm_d     = imm_ext;
        ex_rs_d      = id_instr[RS_LSB +: REG_AW];
        ex_rt_d      = id_instr[RT_LSB +: REG_AW];
        ex_rd_d      = id_instr[RD_LSB +: REG_AW];
        ex_funct_d   = id_instr[FUNCT_LSB +: FUNCT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_funct_q   <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_pc4_q     <= ex_pc4_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_funct_q   <= ex_funct_d;
    end
  end

`ifdef HAZARD_CNT_EN
  logic [15:0] hz_count_q, hz_count_d;

  always_comb begin
    hz_count_d = hz_count_q;
    if (insert_bubble && (hz_count_q != 16'hFFFF)) begin
      hz_count_d = hz_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hz_count_q <= '0;
    end else begin
      hz_count_q <= hz_count_d;
    end
  end

  assign hz_count = hz_count_q;
`else
  assign hz_count = '0;
`endif

  assign ex_valid    = ex_valid_q;
  assign ex_pc4      = ex_pc4_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct    = ex_funct_q;
  assign ex_regdst   = ex_ctrl_q.regdst;
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_memtoreg = ex_ctrl_q.memtoreg;
  assign ex_regwrite = ex_ctrl_q.regwrite;
  assign ex_memread  = ex_ctrl_q.memread;
  assign ex_memwrite = ex_ctrl_q.memwrite;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_aluop    = ex_ctrl_q.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use bubbles, $zero, hold and
// operand-usage rules; counter checks follow HAZARD_CNT_EN.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_pc4, id_rs_data, id_rt_data;
  logic              id_regdst, id_alusrc, id_memtoreg, id_regwrite;
  logic              id_memread, id_memwrite, id_branch, id_jump;
  logic [1:0]        id_aluop;
  logic              ex_hold;
  logic              stall, ex_valid;
  logic [DATA_W-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_funct;
  logic              ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
  logic              ex_memread, ex_memwrite, ex_branch;
  logic [1:0]        ex_aluop;
  logic [15:0]       hz_count;

  int n_checks = 0;
  int n_fail   = 0;
  int hz_exp   = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_jump(id_jump), .id_aluop(id_aluop),
    .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_aluop(ex_aluop), .hz_count(hz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hz_want();
`ifdef HAZARD_CNT_EN
    return 32'(hz_exp);
`else
    return 32'd0;
`endif
  endfunction

  // Applies an ID instruction with the control a MIPS decoder would produce.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] pc4);
    logic [5:0] op;
    op = ins[31:26];
    id_valid = v; id_instr = ins; id_rs_data = rsd; id_rt_data = rtd; id_pc4 = pc4;
    {id_regdst, id_alusrc, id_memtoreg, id_regwrite} = 4'b0;
    {id_memread, id_memwrite, id_branch, id_jump} = 4'b0;
    id_aluop = 2'b00;
    case (op)
      6'h00: begin id_regdst = 1; id_regwrite = 1; id_aluop = 2'b10; end
      6'h23: begin id_alusrc = 1; id_memtoreg = 1; id_regwrite = 1; id_memread = 1; end
      6'h2B: begin id_alusrc = 1; id_memwrite = 1; end
      6'h04: begin id_branch = 1; id_aluop = 2'b01; end
      6'h02: begin id_jump = 1; end
      default: ;
    endcase
    #1;
    $display("t=%0t ID valid=%0d instr=%h pc4=%h stall=%0d", $time, v, ins, pc4, stall);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ex_hold = 1'b1;
    drive(1, 32'h8C220000, 32'hDEAD, 32'hBEEF, 32'h100);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_valid", ex_valid, 0);
    chk("rst_memread", ex_memread, 0);
    chk("rst_pc4", ex_pc4, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_stall", stall, 0);
    chk("rst_hz", hz_count, 0);
    reset = 1'b0;
    ex_hold = 1'b0;

    // Load-use: lw $2 then add $3,$2,$4
    drive(1, 32'h8C220000, 32'h11, 32'h22, 32'h104);
    chk("lu_nostall_empty", stall, 0);
    tick();
    chk("lw_valid", ex_valid, 1);
    chk("lw_memread", ex_memread, 1);
    chk("lw_rs", ex_rs, 1);
    chk("lw_rt", ex_rt, 2);
    chk("lw_pc4", ex_pc4, 32'h104);
    chk("lw_rs_data", ex_rs_data, 32'h11);
    drive(1, 32'h00441820, 32'h33, 32'h44, 32'h108);
    chk("lu_stall", stall, 1);
    tick(); hz_exp++;
    chk("bub_valid", ex_valid, 0);
    chk("bub_regwrite", ex_regwrite, 0);
    chk("bub_memread", ex_memread, 0);
    chk("bub_rt_held", ex_rt, 2);
    chk("bub_pc4_held", ex_pc4, 32'h104);
    chk("bub_stall_drop", stall, 0);
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_rs", ex_rs, 2);
    chk("add_rt", ex_rt, 4);
    chk("add_rd", ex_rd, 3);
    chk("add_funct", ex_funct, 32'h20);
    chk("add_regdst", ex_regdst, 1);
    chk("add_aluop", ex_aluop, 2);
    chk("add_rt_data", ex_rt_data, 32'h44);
    chk("add_stall", stall, 0);
    chk("add_hz", hz_count, hz_want());

    // $zero never hazards
    drive(1, 32'h8C200000, 32'h1, 32'h2, 32'h10C);
    tick();
    chk("lw0_rt", ex_rt, 0);
    chk("lw0_memread", ex_memread, 1);
    drive(1, 32'h00041820, 32'h3, 32'h4, 32'h110);
    chk("zero_nostall", stall, 0);
    tick();
    chk("zero_add_valid", ex_valid, 1);
    chk("zero_add_rd", ex_rd, 3);
    chk("zero_add_pc4", ex_pc4, 32'h110);
    chk("zero_hz", hz_count, hz_want());

    // Negative immediate; unrelated dependent add must not stall
    drive(1, 32'h8C298000, 32'h5, 32'h6, 32'h114);
    tick();
    chk("sext_imm", ex_imm, 32'hFFFF8000);
    drive(1, 32'h00441820, 32'h7, 32'h8, 32'h118);
    chk("unrelated_nostall", stall, 0);
    tick();

    // ex_hold dominance
    drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h120);
    tick();
    drive(1, 32'h00441820, 32'h55, 32'h66, 32'h124);
    ex_hold = 1'b1;
    #1;
    chk("hold_stall0", stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", ex_valid, 1);
      chk("hold_memread", ex_memread, 1);
      chk("hold_pc4", ex_pc4, 32'h120);
      chk("hold_stall", stall, 1);
      chk("hold_hz", hz_count, hz_want());
    end
    ex_hold = 1'b0;
    #1;
    chk("rel_stall", stall, 1);
    tick(); hz_exp++;
    chk("rel_bubble", ex_valid, 0);
    chk("rel_stall_drop", stall, 0);
    tick();
    chk("rel_add_rd", ex_rd, 3);
    chk("rel_add_data", ex_rs_data, 32'h55);
    chk("rel_add_valid", ex_valid, 1);
    chk("rel_hz", hz_count, hz_want());

    // Store reads rt
    drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h130);
    tick();
    drive(1, 32'hACA20004, 32'h9, 32'hA, 32'h134);
    chk("sw_stall", stall, 1);
    tick(); hz_exp++;
    chk("sw_bubble", ex_valid, 0);
    tick();
    chk("sw_memwrite", ex_memwrite, 1);
    chk("sw_imm", ex_imm, 4);
    chk("sw_rs", ex_rs, 5);
    chk("sw_regwrite", ex_regwrite, 0);

    // Jump reads nothing
    drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h140);
    tick();
    drive(1, 32'h08000040, 32'h0, 32'h0, 32'h144);
    chk("j_nostall", stall, 0);
    drive(1, 32'h08400040, 32'h0, 32'h0, 32'h144);
    chk("j_rsfield_nostall", stall, 0);
    tick();
    chk("j_valid", ex_valid, 1);
    chk("j_regwrite", ex_regwrite, 0);
    chk("j_pc4", ex_pc4, 32'h144);

    // Load rt is a destination
    drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h150);
    tick();
    drive(1, 32'h8CE60000, 32'h0, 32'h0, 32'h154);
    chk("lw_lw_nostall", stall, 0);
    drive(1, 32'h8CE20000, 32'h0, 32'h0, 32'h154);
    chk("lw_lw_samert_nostall", stall, 0);
    tick();
    chk("lw2_rt", ex_rt, 2);

    // Branch reads rt (EX holds lw $2,0($7))
    drive(1, 32'h10220000, 32'h0, 32'h0, 32'h160);
    chk("beq_stall", stall, 1);
    tick(); hz_exp++;
    chk("beq_bubble_branch", ex_branch, 0);
    tick();
    chk("beq_branch", ex_branch, 1);
    chk("beq_aluop", ex_aluop, 1);
    chk("beq_hz", hz_count, hz_want());

    // Invalid ID slot never hazards and loads zero control
    drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h170);
    tick();
    drive(0, 32'h00441820, 32'h0, 32'h0, 32'h174);
    chk("inv_nostall", stall, 0);
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_regwrite", ex_regwrite, 0);
    chk("inv_regdst", ex_regdst, 0);

    // Counter saturation
`ifdef HAZARD_CNT_EN
    @(negedge clk);
    force dut.hz_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.hz_count_q;
    hz_exp = 32'hFFFE;
`endif
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h180);
      tick();
      drive(1, 32'h00441820, 32'h0, 32'h0, 32'h184);
      chk("sat_stall", stall, 1);
      tick();
      if (hz_exp < 32'hFFFF) hz_exp++;
      chk("sat_hz", hz_count, hz_want());
      tick();
    end

    // Reset mid-stall clears everything immediately
    drive(1, 32'h8C220000, 32'h0, 32'h0, 32'h190);
    tick();
    drive(1, 32'h00441820, 32'h0, 32'h0, 32'h194);
    chk("pre_rst_stall", stall, 1);
    #2;
    reset = 1'b1;
    #1;
    hz_exp = 0;
    chk("midrst_stall", stall, 0);
    chk("midrst_valid", ex_valid, 0);
    chk("midrst_memread", ex_memread, 0);
    chk("midrst_rt", ex_rt, 0);
    chk("midrst_hz", hz_count, hz_want());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
